// File: rtl/wl_predecoder_seq_if.sv
// wl_predecoder_seq_if: request handshake and predecoded word-line bundle.
// Parity signals exist only when PREDEC_PARITY_EN is defined.
interface wl_predecoder_seq_if #(
    parameter int GROUPS = 2
);
    logic                  req_valid;
    logic [3*GROUPS-1:0]   req_addr;
    logic                  req_ready;
    logic [8*GROUPS-1:0]   pred_n;
    logic                  busy;
    logic                  done;
`ifdef PREDEC_PARITY_EN
    logic                  req_par;
    logic                  par_err;

    modport master (output req_valid, req_addr, req_par,
                    input  req_ready, pred_n, busy, done, par_err);
    modport slave  (input  req_valid, req_addr, req_par,
                    output req_ready, pred_n, busy, done, par_err);
`else
    modport master (output req_valid, req_addr,
                    input  req_ready, pred_n, busy, done);
    modport slave  (input  req_valid, req_addr,
                    output req_ready, pred_n, busy, done);
`endif
endinterface

// File: rtl/wl_predecoder_seq.sv
// wl_predecoder_seq: sequenced 3-to-8 word-line predecoder with setup/pulse/recovery window.
// Optional request parity check enabled by defining PREDEC_PARITY_EN.
module wl_predecoder_seq #(
    parameter int GROUPS    = 2,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic                clk,
    input  logic                rst,
    wl_predecoder_seq_if.slave  bus
);
    localparam int ADDR_W = 3 * GROUPS;
    localparam int PRED_W = 8 * GROUPS;
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] GAP_LD   = 4'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RECOVER} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PRED_W-1:0]   pred_q, pred_d;
    logic                done_q, done_d;
    logic                accept, par_ok;

    assign accept = bus.req_valid && (state_q == IDLE);
`ifdef PREDEC_PARITY_EN
    logic par_err_q;
    assign par_ok = ~^{bus.req_addr, bus.req_par};
    always_ff @(posedge clk) begin
        if (rst) par_err_q <= 1'b0;
        else     par_err_q <= accept && !par_ok;
    end
    assign bus.par_err = par_err_q;
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pred_d  = '1;
        case (state_q)
            IDLE: begin
                state_d = (accept && par_ok) ? SETUP : IDLE;
                addr_d  = (accept && par_ok) ? bus.req_addr : addr_q;
            end
            SETUP: begin
                state_d = ACTIVE;
                cnt_d   = PULSE_LD;
            end
            ACTIVE: begin
                done_d  = (cnt_q == 4'd0);
                state_d = (cnt_q != 4'd0) ? ACTIVE : (GAP_CYC == 0) ? IDLE : RECOVER;
                cnt_d   = (cnt_q == 4'd0) ? GAP_LD : cnt_q - 4'd1;
            end
            default: begin
                state_d = (cnt_q == 4'd0) ? IDLE : RECOVER;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            end
        endcase
        // lines are computed from next state so the registered output lines up with ACTIVE
        if (state_d == ACTIVE)
            for (int g = 0; g < GROUPS; g++)
                pred_d[8*g +: 8] = ~(8'd1 << addr_d[3*g +: 3]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= 4'd0;
            pred_q  <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            pred_q  <= pred_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.pred_n    = pred_q;
endmodule

// File: tb/tb_wl_predecoder_seq.sv
// tb_wl_predecoder_seq: directed checks of the sequenced predecoder at default parameters.
// Build with PREDEC_PARITY_EN defined to include the parity scenario.
module tb_wl_predecoder_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    wl_predecoder_seq_if #(.GROUPS(2)) bus ();

    wl_predecoder_seq #(.GROUPS(2), .PULSE_CYC(2), .GAP_CYC(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [5:0] a);
        bus.req_valid = v;
        bus.req_addr  = a;
`ifdef PREDEC_PARITY_EN
        bus.req_par   = ^a;
`endif
    endtask

    task automatic test_reset();
        drive(1'b0, 6'o00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (bus.pred_n !== 16'hFFFF) begin miscompares++; $display("FAIL reset_pred got %h exp FFFF", bus.pred_n); end
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", bus.done); end
`ifdef PREDEC_PARITY_EN
        vectors++; if (bus.par_err !== 1'b0) begin miscompares++; $display("FAIL reset_par_err got %b exp 0", bus.par_err); end
`endif
    endtask

    task automatic test_single();
        drive(1'b1, 6'o53);
        @(negedge clk);
        drive(1'b0, 6'o53);
        vectors++; if (bus.pred_n !== 16'hFFFF) begin miscompares++; $display("FAIL single_setup_pred got %h exp FFFF", bus.pred_n); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_setup_busy got %b exp 1", bus.busy); end
        vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL single_setup_ready got %b exp 0", bus.req_ready); end
        @(negedge clk);
        vectors++; if (bus.pred_n !== 16'hDFF7) begin miscompares++; $display("FAIL single_act1_pred got %h exp DFF7", bus.pred_n); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL single_act1_done got %b exp 0", bus.done); end
        @(negedge clk);
        vectors++; if (bus.pred_n !== 16'hDFF7) begin miscompares++; $display("FAIL single_act2_pred got %h exp DFF7", bus.pred_n); end
        @(negedge clk);
        vectors++; if (bus.pred_n !== 16'hFFFF) begin miscompares++; $display("FAIL single_rec_pred got %h exp FFFF", bus.pred_n); end
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL single_rec_done got %b exp 1", bus.done); end
        vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL single_rec_ready got %b exp 0", bus.req_ready); end
        @(negedge clk);
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL single_idle_ready got %b exp 1", bus.req_ready); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy got %b exp 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL single_idle_done got %b exp 0", bus.done); end
    endtask

    task automatic test_sweep();
        logic [5:0]  av;
        logic [15:0] exp;
        drive(1'b1, 6'o00);
        for (int a = 0; a < 64; a++) begin
            av  = 6'(a);
            exp = {~(8'd1 << av[5:3]), ~(8'd1 << av[2:0])};
            @(negedge clk);
            drive(a != 63, 6'(a + 1));
            vectors++; if (bus.pred_n !== 16'hFFFF || bus.busy !== 1'b1) begin miscompares++; $display("FAIL sweep_setup a=%0d got pred %h busy %b exp FFFF 1", a, bus.pred_n, bus.busy); end
            @(negedge clk);
            vectors++; if (bus.pred_n !== exp) begin miscompares++; $display("FAIL sweep_act1 a=%0d got %h exp %h", a, bus.pred_n, exp); end
            @(negedge clk);
            vectors++; if (bus.pred_n !== exp) begin miscompares++; $display("FAIL sweep_act2 a=%0d got %h exp %h", a, bus.pred_n, exp); end
            @(negedge clk);
            vectors++; if (bus.done !== 1'b1 || bus.pred_n !== 16'hFFFF) begin miscompares++; $display("FAIL sweep_rec a=%0d got done %b pred %h exp 1 FFFF", a, bus.done, bus.pred_n); end
            @(negedge clk);
            vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL sweep_ready a=%0d got %b exp 1", a, bus.req_ready); end
        end
    endtask

    task automatic test_busy();
        drive(1'b1, 6'o00);
        @(negedge clk);
        drive(1'b1, 6'o77);
        @(negedge clk);
        vectors++; if (bus.pred_n !== 16'hFEFE) begin miscompares++; $display("FAIL busy_act1 got %h exp FEFE", bus.pred_n); end
        @(negedge clk);
        vectors++; if (bus.pred_n !== 16'hFEFE) begin miscompares++; $display("FAIL busy_act2 got %h exp FEFE", bus.pred_n); end
        @(negedge clk);
        vectors++; if (bus.req_ready !== 1'b0 || bus.done !== 1'b1) begin miscompares++; $display("FAIL busy_rec got ready %b done %b exp 0 1", bus.req_ready, bus.done); end
        @(negedge clk);
        vectors++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_idle got ready %b busy %b exp 1 0", bus.req_ready, bus.busy); end
        @(negedge clk);
        drive(1'b0, 6'o77);
        vectors++; if (bus.busy !== 1'b1 || bus.pred_n !== 16'hFFFF) begin miscompares++; $display("FAIL busy_second_setup got busy %b pred %h exp 1 FFFF", bus.busy, bus.pred_n); end
        @(negedge clk);
        vectors++; if (bus.pred_n !== 16'h7F7F) begin miscompares++; $display("FAIL busy_second_act got %h exp 7F7F", bus.pred_n); end
        repeat (3) @(negedge clk);
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL busy_second_idle got %b exp 1", bus.req_ready); end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 6'o12);
        @(negedge clk);
        drive(1'b0, 6'o12);
        @(negedge clk);
        vectors++; if (bus.pred_n !== 16'hFDFB) begin miscompares++; $display("FAIL midrst_act1 got %h exp FDFB", bus.pred_n); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (bus.pred_n !== 16'hFFFF) begin miscompares++; $display("FAIL midrst_pred got %h exp FFFF", bus.pred_n); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %b exp 0", bus.done); end
        vectors++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_state got busy %b ready %b exp 0 1", bus.busy, bus.req_ready); end
        @(negedge clk);
        vectors++; if (bus.done !== 1'b0 || bus.pred_n !== 16'hFFFF) begin miscompares++; $display("FAIL midrst_after got done %b pred %h exp 0 FFFF", bus.done, bus.pred_n); end
    endtask

`ifdef PREDEC_PARITY_EN
    task automatic test_parity();
        drive(1'b1, 6'o01);
        bus.req_par = 1'b0;
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL par_ready got %b exp 1", bus.req_ready); end
        @(negedge clk);
        drive(1'b0, 6'o01);
        vectors++; if (bus.par_err !== 1'b1) begin miscompares++; $display("FAIL par_err_pulse got %b exp 1", bus.par_err); end
        vectors++; if (bus.busy !== 1'b0 || bus.pred_n !== 16'hFFFF) begin miscompares++; $display("FAIL par_idle got busy %b pred %h exp 0 FFFF", bus.busy, bus.pred_n); end
        @(negedge clk);
        vectors++; if (bus.par_err !== 1'b0 || bus.pred_n !== 16'hFFFF) begin miscompares++; $display("FAIL par_err_clear got %b pred %h exp 0 FFFF", bus.par_err, bus.pred_n); end
        drive(1'b1, 6'o01);
        @(negedge clk);
        drive(1'b0, 6'o01);
        vectors++; if (bus.busy !== 1'b1 || bus.par_err !== 1'b0) begin miscompares++; $display("FAIL par_good_setup got busy %b err %b exp 1 0", bus.busy, bus.par_err); end
        @(negedge clk);
        vectors++; if (bus.pred_n !== 16'hFEFD) begin miscompares++; $display("FAIL par_good_act got %h exp FEFD", bus.pred_n); end
        repeat (3) @(negedge clk);
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL par_good_idle got %b exp 1", bus.req_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_busy();
        test_mid_reset();
`ifdef PREDEC_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
